// File: rtl/data_mem_if.sv
// Purpose: bus between the MEM-stage control path and the data memory.
//   master modport: drives MEM_memwrite, MEM_memread, addr, wdata and samples rdata.
//   slave  modport: the memory side, which drives rdata.
// Signal summary:
//   MEM_memwrite  write enable
//   MEM_memread   read enable
//   addr          word address (ADDR_W bits)
//   wdata         write data (DATA_W bits)
//   rdata         combinational read data (DATA_W bits)
interface data_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              MEM_memwrite;
  logic              MEM_memread;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output MEM_memwrite, MEM_memread, addr, wdata,
    input  rdata
  );

  modport slave (
    input  MEM_memwrite, MEM_memread, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/data_mem.sv
// Purpose: word-addressed data memory for the MEM stage of the pipeline.
//   DEPTH words of DATA_W bits; synchronous write, combinational read gated
//   by MEM_memread (rdata is 0 while the read enable is low).
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-high, clears the whole array; beats a write
//   bus    data_mem_if.slave (MEM_memwrite, MEM_memread, addr, wdata, rdata)
// Parameters: DATA_W, ADDR_W, DEPTH (DEPTH must equal 2**ADDR_W and the
//   interface instance must use the same DATA_W/ADDR_W).
// Optional feature macro: DATA_MEM_WR_BYPASS_EN
//   defined   : a cycle with read and write both enabled (and reset low)
//               forwards wdata straight to rdata before the edge.
//   undefined : such a cycle shows the old stored word until the edge.
module data_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_c;

  // Storage: reset clears every word and takes priority over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.MEM_memwrite) begin
      mem_q[bus.addr] <= bus.wdata;
    end
  end

  // Read path: zero when reads are disabled, otherwise the addressed word.
  always_comb begin
    rdata_c = '0;
    if (bus.MEM_memread) begin
`ifdef DATA_MEM_WR_BYPASS_EN
      // The write targets the same addr, so forwarding wdata is always correct.
      if (bus.MEM_memwrite && !reset) begin
        rdata_c = bus.wdata;
      end else begin
        rdata_c = mem_q[bus.addr];
      end
`else
      rdata_c = mem_q[bus.addr];
`endif
    end
  end

  assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

`ifdef DATA_MEM_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic reset;

  data_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference contents, maintained from the behavioural rules alone.
  logic [DATA_W-1:0] model [DEPTH];

  typedef struct {
    logic              rst;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] exp_pre;
    logic [DATA_W-1:0] exp_post;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: rdata=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected rdata for the current inputs against the model contents.
  function automatic logic [DATA_W-1:0] model_rd(input logic rst, input logic we,
      input logic re, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    if (!re) return '0;
    if (BYPASS && we && !rst) return wd;
    return model[a];
  endfunction

  // Apply one cycle of inputs: check rdata before the edge, clock, check
  // again after the edge with the inputs still held, and advance the model.
  task automatic step(input string name, input logic rst, input logic we,
      input logic re, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
      input logic [DATA_W-1:0] exp_pre, input logic [DATA_W-1:0] exp_post);
    reset            = rst;
    bus.MEM_memwrite = we;
    bus.MEM_memread  = re;
    bus.addr         = a;
    bus.wdata        = wd;
    #1;
    check({name, " pre"}, bus.rdata, exp_pre);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    end else if (we) begin
      model[a] = wd;
    end
    #1;
    check({name, " post"}, bus.rdata, exp_post);
    @(negedge clk);
  endtask

  // Random cycle with expectations taken from the model.
  task automatic rand_step(input int n);
    logic              rst;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pre;
    logic [DATA_W-1:0] post;
    rst = ($urandom_range(0, 49) == 0);
    we  = 1'(($urandom() & 1));
    re  = 1'(($urandom() & 1));
    a   = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom()) : ADDR_W'($urandom_range(0, 15));
    wd  = DATA_W'($urandom());
    pre = model_rd(rst, we, re, a, wd);
    if (rst) post = (re && !(BYPASS && we && !rst)) ? '0 : model_rd(rst, we, re, a, wd);
    else begin
      post = re ? ((BYPASS && we) ? wd : (we ? wd : model[a])) : '0;
    end
    step($sformatf("rand%0d", n), rst, we, re, a, wd, pre, post);
  endtask

  initial begin
    logic [DATA_W-1:0] byp5;
    logic [DATA_W-1:0] byp6;
    byp5 = BYPASS ? 32'd9 : 32'd7;
    byp6 = BYPASS ? 32'h55 : 32'h0;

    //           rst   we    re    addr   wdata          pre           post
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd10,  32'd0,         32'd0,        32'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'd10,  32'd0,         32'd0,        32'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'd10,  32'd20,        32'd0,        32'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'd10,  32'd30,        32'd20,       32'd20};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'd10,  32'd40,        32'd0,        32'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'd10,  32'd40,        32'd20,       32'd20};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'd255, 32'hDEADBEEF,  32'd0,        32'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'd0,   32'h12345678,  32'd0,        32'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'd255, 32'd0,         32'hDEADBEEF, 32'hDEADBEEF};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'd0,   32'd0,         32'h12345678, 32'h12345678};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 8'd10,  32'd99,        32'd20,       32'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'd10,  32'd0,         32'd0,        32'd0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'd5,   32'd7,         32'd0,        32'd0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 8'd5,   32'd9,         byp5,         32'd9};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 8'd5,   32'd0,         32'd9,        32'd9};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 8'd6,   32'h55,        byp6,         32'h55};

    reset            = 1'b1;
    bus.MEM_memwrite = 1'b0;
    bus.MEM_memread  = 1'b0;
    bus.addr         = '0;
    bus.wdata        = '0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].we, tbl[i].re, tbl[i].a,
           tbl[i].wd, tbl[i].exp_pre, tbl[i].exp_post);
    end

    // Fill several words, then a reset while reading one must wipe them all.
    step("fill1",   1'b0, 1'b1, 1'b0, 8'd1,   32'hA1, 32'd0, 32'd0);
    step("fill2",   1'b0, 1'b1, 1'b0, 8'd2,   32'hA2, 32'd0, 32'd0);
    step("fill254", 1'b0, 1'b1, 1'b0, 8'd254, 32'hA3, 32'd0, 32'd0);
    step("rdfill2", 1'b0, 1'b0, 1'b1, 8'd2,   32'd0,  32'hA2, 32'hA2);
    step("midrst",  1'b1, 1'b0, 1'b1, 8'd1,   32'd0,  32'hA1, 32'd0);
    step("clr2",    1'b0, 1'b0, 1'b1, 8'd2,   32'd0,  32'd0, 32'd0);
    step("clr254",  1'b0, 1'b0, 1'b1, 8'd254, 32'd0,  32'd0, 32'd0);
    step("clr6",    1'b0, 1'b0, 1'b1, 8'd6,   32'd0,  32'd0, 32'd0);

    for (int n = 0; n < 1500; n++) rand_step(n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-addressed data memory for the MEM stage of the CPU pipeline.
- Stores DEPTH words of DATA_W bits.
- Synchronous write on the rising clock edge; combinational read gated by the read enable.
- Driven directly by the MEM-stage control signals (MEM_memread, MEM_memwrite) and the ALU-computed address.

Parameters:
- DATA_W, 32: width of each memory word and of wdata/rdata.
- ADDR_W, 8: address width.
- DEPTH, 256: number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; clears whole array.
- MEM_memwrite  input  1  write enable.
- MEM_memread  input  1  read enable.
- addr  input  ADDR_W  word address.
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  read data.

Behaviour:
- Storage: array mem[0..DEPTH-1] of DATA_W-bit words. No byte enables; full-word access only.
- Reset (synchronous, active-high):
  - At a rising edge with reset=1, every location is set to 0.
  - reset has priority over MEM_memwrite; no write occurs in a reset cycle.
  - Reset asserted mid-operation discards all prior contents at that edge.
- Write:
  - At a rising edge with reset=0 and MEM_memwrite=1, mem[addr] <= wdata.
  - Write latency: 1 edge; the new value is visible on rdata immediately after that edge.
- Read (combinational, zero latency):
  - rdata = mem[addr] when MEM_memread=1.
  - rdata = 0 when MEM_memread=0.
  - No clock is needed for a read.
- Simultaneous read and write, same address, same cycle:
  - Before the edge, rdata shows the old contents.
  - After the edge, rdata shows the new contents (read-old-then-new).
  - Exception: the optional bypass below changes this.
- Both enables low: memory unchanged, rdata = 0.
- wdata is ignored whenever MEM_memwrite=0.
- Address range:
  - All 2**ADDR_W addresses are valid; no wrap or aliasing.
  - addr 0 and addr DEPTH-1 are independent locations.
- Output after reset: mem all zero, so rdata = 0 whether or not MEM_memread is set.
- X handling: before the first reset, contents are undefined; the bench must reset first.
- No other outputs, no handshake, no stall; the block is always ready.

Optional Feature:
- Macro: DATA_MEM_WR_BYPASS_EN.
- Defined: when MEM_memread=1, MEM_memwrite=1 and reset=0 in the same cycle, rdata = wdata combinationally (write-first forwarding) before the edge. This applies regardless of address match because the write targets addr. The stored value after the edge is identical.
- Not defined: rdata shows the old mem[addr] until the edge, as in Behaviour.
- Read-only and write-only cycles are unaffected either way.

Test Plan:
- Reset: reset=1 for 1 edge, then MEM_memread=1, addr=10 -> rdata=0.
- Write/read: MEM_memwrite=1, addr=10, wdata=20 for 1 edge; then MEM_memread=1, MEM_memwrite=0, wdata=30 -> rdata=20, and mem[10] stays 20 (wdata ignored).
- Read disabled: MEM_memread=0, MEM_memwrite=0, addr=10, wdata=40 -> rdata=0; re-enabling the read then gives rdata=20.
- Boundaries:
  - Write 0xDEADBEEF to addr=255 and 0x12345678 to addr=0.
  - Read addr 255 -> 0xDEADBEEF; read addr 0 -> 0x12345678 (no aliasing).
- Reset priority and mid-operation reset:
  - With mem[10]=20, assert reset=1 together with MEM_memwrite=1, wdata=99 for 1 edge.
  - Then read addr 10 -> rdata=0.
- Simultaneous read+write, addr=5, old value 7, wdata=9:
  - Before the edge: rdata=7 (rdata=9 with DATA_MEM_WR_BYPASS_EN).
  - After the edge: rdata=9.
